// File: rtl/axi_wr_arbiter.sv
// Round-robin write arbiter sharing one AXI slave AW/W/B port among masters M0-M2, one transaction at a time.
// Latency: one arbitration cycle in IDLE; AW, W and B then pass combinationally to and from the granted master.
// Backpressure: slave READY and master BREADY pass straight through; other masters see READY low until B completes.
module axi_wr_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3*ID_W-1:0]       AWID_M,
    input  logic [3*ADDR_W-1:0]     AWADDR_M,
    input  logic [3*LEN_W-1:0]      AWLEN_M,
    input  logic [8:0]              AWSIZE_M,
    input  logic [5:0]              AWBURST_M,
    input  logic [2:0]              AWVALID_M,
    output logic [2:0]              AWREADY_M,
    input  logic [3*DATA_W-1:0]     WDATA_M,
    input  logic [3*(DATA_W/8)-1:0] WSTRB_M,
    input  logic [2:0]              WLAST_M,
    input  logic [2:0]              WVALID_M,
    output logic [2:0]              WREADY_M,
    output logic [ID_W-1:0]         BID_M,
    output logic [1:0]              BRESP_M,
    output logic [2:0]              BVALID_M,
    input  logic [2:0]              BREADY_M,
    output logic [ID_W+3:0]         AWID_S,
    output logic [ADDR_W-1:0]       AWADDR_S,
    output logic [LEN_W-1:0]        AWLEN_S,
    output logic [2:0]              AWSIZE_S,
    output logic [1:0]              AWBURST_S,
    output logic                    AWVALID_S,
    input  logic                    AWREADY_S,
    output logic [DATA_W-1:0]       WDATA_S,
    output logic [DATA_W/8-1:0]     WSTRB_S,
    output logic                    WLAST_S,
    output logic                    WVALID_S,
    input  logic                    WREADY_S,
    input  logic [ID_W+3:0]         BID_S,
    input  logic [1:0]              BRESP_S,
    input  logic                    BVALID_S,
    output logic                    BREADY_S,
    output logic [1:0]              grant,
    output logic                    wlast_err
);
    localparam int SW = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

    state_t           state;
    logic [1:0]       last_grant;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat;
    logic [1:0]       winner;
    logic [2:0]       own;
    logic             aw_hs, w_hs, b_hs, tag_ok, last_beat, b_ok;

    logic [ID_W-1:0]   sel_awid;
    logic [ADDR_W-1:0] sel_awaddr;
    logic [LEN_W-1:0]  sel_awlen;
    logic [2:0]        sel_awsize;
    logic [1:0]        sel_awburst;
    logic              sel_awvalid;
    logic [DATA_W-1:0] sel_wdata;
    logic [SW-1:0]     sel_wstrb;
    logic              sel_wlast, sel_wvalid, sel_bready;

    // grant is non-zero exactly while a transaction is in flight, so it alone selects the owner
    always_comb begin
        own         = '0;
        sel_awid    = '0;
        sel_awaddr  = '0;
        sel_awlen   = '0;
        sel_awsize  = '0;
        sel_awburst = '0;
        sel_awvalid = 1'b0;
        sel_wdata   = '0;
        sel_wstrb   = '0;
        sel_wlast   = 1'b0;
        sel_wvalid  = 1'b0;
        sel_bready  = 1'b0;
        for (int m = 0; m < 3; m++) begin
            if (grant == 2'(m + 1)) begin
                own[m]      = 1'b1;
                sel_awid    = AWID_M[m*ID_W +: ID_W];
                sel_awaddr  = AWADDR_M[m*ADDR_W +: ADDR_W];
                sel_awlen   = AWLEN_M[m*LEN_W +: LEN_W];
                sel_awsize  = AWSIZE_M[m*3 +: 3];
                sel_awburst = AWBURST_M[m*2 +: 2];
                sel_awvalid = AWVALID_M[m];
                sel_wdata   = WDATA_M[m*DATA_W +: DATA_W];
                sel_wstrb   = WSTRB_M[m*SW +: SW];
                sel_wlast   = WLAST_M[m];
                sel_wvalid  = WVALID_M[m];
                sel_bready  = BREADY_M[m];
            end
        end
    end

    // Search starts one past the previous owner; result is the grant code (0 = nobody asking)
    always_comb begin
        winner = 2'd0;
        case (last_grant)
            2'd0:    winner = AWVALID_M[1] ? 2'd2 : AWVALID_M[2] ? 2'd3 : AWVALID_M[0] ? 2'd1 : 2'd0;
            2'd1:    winner = AWVALID_M[2] ? 2'd3 : AWVALID_M[0] ? 2'd1 : AWVALID_M[1] ? 2'd2 : 2'd0;
            default: winner = AWVALID_M[0] ? 2'd1 : AWVALID_M[1] ? 2'd2 : AWVALID_M[2] ? 2'd3 : 2'd0;
        endcase
    end

    assign last_beat = (beat == len_q);
    assign tag_ok    = (BID_S[ID_W +: 4] == {2'b00, grant});
    assign b_ok      = (state == B) && tag_ok;

    assign AWVALID_S  = (state == AW) && sel_awvalid;
    assign AWREADY_M  = (state == AW && AWREADY_S) ? own : 3'b000;
    assign AWID_S     = (state == AW) ? {2'b00, grant, sel_awid} : '0;
    assign AWADDR_S   = (state == AW) ? sel_awaddr : '0;
    assign AWLEN_S    = (state == AW) ? sel_awlen : '0;
    assign AWSIZE_S   = (state == AW) ? sel_awsize : '0;
    assign AWBURST_S  = (state == AW) ? sel_awburst : '0;
    assign aw_hs      = AWVALID_S && AWREADY_S;

    assign WVALID_S   = (state == W) && sel_wvalid;
    assign WREADY_M   = (state == W && WREADY_S) ? own : 3'b000;
    assign WDATA_S    = (state == W) ? sel_wdata : '0;
    assign WSTRB_S    = (state == W) ? sel_wstrb : '0;
    assign WLAST_S    = (state == W) && last_beat;
    assign w_hs       = WVALID_S && WREADY_S;

    // A response carrying another master's tag is never forwarded or accepted
    assign BREADY_S   = b_ok && sel_bready;
    assign BVALID_M   = (b_ok && BVALID_S) ? own : 3'b000;
    assign BID_M      = (state == B) ? BID_S[ID_W-1:0] : '0;
    assign BRESP_M    = (state == B) ? BRESP_S : '0;
    assign b_hs       = BVALID_S && BREADY_S;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd2;
            len_q      <= '0;
            beat       <= '0;
            wlast_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (winner != 2'd0) begin
                        grant <= winner;
                        state <= AW;
                    end
                end
                AW: begin
                    if (aw_hs) begin
                        len_q <= sel_awlen;
                        beat  <= '0;
                        state <= W;
                    end
                end
                W: begin
                    if (w_hs) begin
                        if (sel_wlast != last_beat)
                            wlast_err <= 1'b1;
                        if (last_beat)
                            state <= B;
                        else
                            beat <= beat + 1'b1;
                    end
                end
                B: begin
                    if (BVALID_S && !tag_ok)
                        wlast_err <= 1'b1;
                    if (b_hs) begin
                        last_grant <= grant - 2'd1;
                        grant      <= 2'd0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Write-path arbiter sharing one AXI slave write port (AW/W/B) among three masters M0–M2.
- Grants one complete write transaction at a time with round-robin fairness.
- Locks the W channel to the winner until its last beat, then routes the B response back.
- Sits in the interconnect beside the read-address arbiter, one instance per slave port.

Parameters:
ID_W, 4, master-side ID width
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
LEN_W, 4, burst length field width (beats = LEN+1)

Ports:
clk  in  1  clock
rst  in  1  async active-low reset
AWID_M  in  3*ID_W  per-master AW ID, slice m = master m
AWADDR_M  in  3*ADDR_W  per-master AW address
AWLEN_M  in  3*LEN_W  per-master burst length
AWSIZE_M  in  9  per-master size, 3 bits each
AWBURST_M  in  6  per-master burst type, 2 bits each
AWVALID_M  in  3  per-master AW valid
AWREADY_M  out  3  per-master AW ready
WDATA_M  in  3*DATA_W  per-master write data
WSTRB_M  in  3*DATA_W/8  per-master strobes
WLAST_M  in  3  per-master last flag (monitored only)
WVALID_M  in  3  per-master W valid
WREADY_M  out  3  per-master W ready
BID_M  out  ID_W  response ID (low ID_W bits of BID_S), shared
BRESP_M  out  2  response code, shared
BVALID_M  out  3  per-master B valid
BREADY_M  in  3  per-master B ready
AWID_S  out  ID_W+4  {tag, AWID}; tag 4'b0001/0010/0011 for M0/M1/M2
AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S  out  ADDR_W/LEN_W/3/2  muxed AW fields
AWVALID_S  out  1  slave AW valid
AWREADY_S  in  1  slave AW ready
WDATA_S, WSTRB_S  out  DATA_W, DATA_W/8  muxed write data/strobe
WLAST_S  out  1  generated last flag
WVALID_S  out  1  slave W valid
WREADY_S  in  1  slave W ready
BID_S  in  ID_W+4  slave response ID
BRESP_S  in  2  slave response
BVALID_S  in  1  slave B valid
BREADY_S  out  1  slave B ready
grant  out  2  0 idle, 1/2/3 = M0/M1/M2 owns port
wlast_err  out  1  sticky: master WLAST disagreed with beat count

Behaviour:
- Reset (rst low, async): state IDLE, grant 0, last_grant M2 (so M0 wins first), beat count 0, wlast_err 0. All *VALID_S, *READY_M, BVALID_M, BREADY_S = 0; muxed data outputs = 0.
- FSM IDLE -> AW -> W -> B -> IDLE. One transaction at a time; no outstanding overlap.
- IDLE: if any AWVALID_M, register the round-robin winner into grant (search order last_grant+1, +2, +3 mod 3) and go to AW next cycle. There is one cycle of arbitration latency; nothing is driven to the slave in IDLE.
- AW:
  - AWVALID_S = AWVALID_M[g]; AWREADY_M[g] = AWREADY_S; other AWREADY_M = 0.
  - Latch AWLEN on handshake, clear beat count, go to W.
  - A withdrawn AWVALID does not release the grant.
- W:
  - WVALID_S = WVALID_M[g]; WREADY_M[g] = WREADY_S; WLAST_S = (beat == len).
  - Each handshake increments beat. The handshake with beat == len goes to B.
  - On any handshake where WLAST_M[g] != WLAST_S, set wlast_err; the counter still governs termination.
- B:
  - BREADY_S = BREADY_M[g]; BVALID_M[g] = BVALID_S.
  - If BID_S tag != grant, hold BREADY_S = 0, BVALID_M = 0, and set wlast_err.
  - On handshake, last_grant <= g, grant <= 0, go to IDLE.
- Non-granted masters always see READY/BVALID = 0. Requests arriving mid-transaction wait.
- Simultaneous requests in IDLE are resolved purely by the round-robin pointer.
- Valid-to-slave path is combinational from the granted master; no data buffering.

Test Plan:
- Reset, M0 single write len 0, AWREADY_S/WREADY_S/BVALID_S high -> AWID_S={0001,id}; WLAST_S on beat 0; BVALID_M=001; grant returns 0.
- M0, M1, M2 assert AWVALID together with 3 back-to-back len-1 writes -> grants M0, M1, M2 in order; each sees exactly 2 W beats.
- M1 len 3 burst, WREADY_S toggles every other cycle -> WLAST_S only on 4th accepted beat; M0 AW request during burst has AWREADY_M[0]=0 until B done.
- M2 drives WLAST on beat 1 of len 2 -> wlast_err=1; burst still ends after beat 2.
- BVALID_S held high, BREADY_M[1] low for 5 cycles -> BVALID_M=010 held; no new grant until BREADY_M[1] rises.
- rst low during W state -> all outputs 0 asynchronously; after release M0 wins first.
